// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: registered NUM_IN:1 select stage with a valid/ready handshake.
// Define MUX_NX1_PIPE_SKID_EN to add a 1-entry skid buffer and a registered in_ready.
module mux_nx1_pipe #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 2,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    logic [WIDTH-1:0] masked [NUM_IN];
    logic [WIDTH-1:0] sel_word;
    logic             sel_oor;
    logic             out_free;
    logic             accept;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q,  out_sel_d;
    logic             out_err_q,  out_err_d;
    logic             out_valid_q, out_valid_d;

    // An out-of-range select matches no mask, so sel_word is already zero for it.
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
        assign masked[gi] = (32'(in_sel) == gi) ? in_data[gi*WIDTH +: WIDTH] : '0;
    end

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            sel_word = sel_word | masked[k];
        end
    end

    assign sel_oor  = (32'(in_sel) >= NUM_IN);
    assign out_free = !out_valid_q || out_ready;
    // A word offered during flush is never taken, whatever in_ready shows.
    assign accept   = in_valid && in_ready && !flush;

`ifdef MUX_NX1_PIPE_SKID_EN

    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0] skid_sel_q,  skid_sel_d;
    logic             skid_err_q,  skid_err_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q,  in_ready_d;

    assign in_ready = in_ready_q;

    always_comb begin
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        out_err_d    = out_err_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_sel_d   = skid_sel_q;
        skid_err_d   = skid_err_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            // in_ready is low whenever the skid is full, so accept and a skid drain never coincide.
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_sel_d    = skid_sel_q;
                out_err_d    = skid_err_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_data_d  = sel_word;
                out_sel_d   = in_sel;
                out_err_d   = sel_oor;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_data_d  = sel_word;
            skid_sel_d   = in_sel;
            skid_err_d   = sel_oor;
            skid_valid_d = 1'b1;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data_q  <= '0;
            skid_sel_q   <= '0;
            skid_err_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            skid_data_q  <= skid_data_d;
            skid_sel_q   <= skid_sel_d;
            skid_err_q   <= skid_err_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

`else

    assign in_ready = out_free;

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_data_d  = sel_word;
            out_sel_d   = in_sel;
            out_err_d   = sel_oor;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;
    assign sel_err   = out_err_q && out_valid_q;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Bench for mux_nx1_pipe: a 5-bit 2:1 instance and an 8-bit 3:1 instance, scoreboard-checked.
`timescale 1ns/1ps
module tb_mux_nx1_pipe;

    localparam int WA = 5;
    localparam int NA = 2;
    localparam int SA = $clog2(NA);
    localparam int WB = 8;
    localparam int NB = 3;
    localparam int SB = $clog2(NB);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic             flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, sel_err_a;
    logic [NA*WA-1:0] in_data_a;
    logic [SA-1:0]    in_sel_a, out_sel_a;
    logic [WA-1:0]    out_data_a;

    logic             flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, sel_err_b;
    logic [NB*WB-1:0] in_data_b;
    logic [SB-1:0]    in_sel_b, out_sel_b;
    logic [WB-1:0]    out_data_b;

    int total = 0;
    int bad   = 0;
    int out_cnt_a = 0;
    int out_cnt_b = 0;

    typedef struct {
        logic [7:0] data;
        logic [1:0] sel;
        logic       err;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    mux_nx1_pipe #(.WIDTH(WA), .NUM_IN(NA)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush_a),
        .in_data(in_data_a), .in_sel(in_sel_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_sel(out_sel_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .sel_err(sel_err_a)
    );

    mux_nx1_pipe #(.WIDTH(WB), .NUM_IN(NB)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_b),
        .in_data(in_data_b), .in_sel(in_sel_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_sel(out_sel_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .sel_err(sel_err_b)
    );

    // Reference selection: input 'sel' of packed data, zero when the select is out of range.
    function automatic logic [7:0] ref_mux(input logic [23:0] d, input int sel, input int w, input int n);
        logic [23:0] sh;
        if (sel >= n) return 8'h00;
        sh = d >> (sel * w);
        return sh[7:0] & 8'((1 << w) - 1);
    endfunction

    // Scoreboards: sample between edges; a transfer pops, an accept pushes.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n === 1'b1) begin
            if (out_valid_a && out_ready_a) begin
                total++;
                if (q_a.size() == 0) begin
                    bad++;
                    $display("FAIL sb_a_unexpected: got data=%h sel=%0d err=%0d, required no word", out_data_a, out_sel_a, sel_err_a);
                end else begin
                    e = q_a.pop_front();
                    if (out_data_a !== e.data[WA-1:0] || out_sel_a !== e.sel[SA-1:0] || sel_err_a !== e.err) begin
                        bad++;
                        $display("FAIL sb_a_word: got data=%h sel=%0d err=%0d, required data=%h sel=%0d err=%0d",
                                 out_data_a, out_sel_a, sel_err_a, e.data[WA-1:0], e.sel[SA-1:0], e.err);
                    end
                end
                out_cnt_a++;
            end
            if (flush_a) begin
                q_a.delete();
            end else if (in_valid_a && in_ready_a) begin
                e.data = ref_mux(24'(in_data_a), int'(in_sel_a), WA, NA);
                e.sel  = 2'(in_sel_a);
                e.err  = (int'(in_sel_a) >= NA);
                q_a.push_back(e);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n === 1'b1) begin
            if (out_valid_b && out_ready_b) begin
                total++;
                if (q_b.size() == 0) begin
                    bad++;
                    $display("FAIL sb_b_unexpected: got data=%h sel=%0d err=%0d, required no word", out_data_b, out_sel_b, sel_err_b);
                end else begin
                    e = q_b.pop_front();
                    if (out_data_b !== e.data || out_sel_b !== e.sel[SB-1:0] || sel_err_b !== e.err) begin
                        bad++;
                        $display("FAIL sb_b_word: got data=%h sel=%0d err=%0d, required data=%h sel=%0d err=%0d",
                                 out_data_b, out_sel_b, sel_err_b, e.data, e.sel[SB-1:0], e.err);
                    end
                end
                out_cnt_b++;
            end
            if (flush_b) begin
                q_b.delete();
            end else if (in_valid_b && in_ready_b) begin
                e.data = ref_mux(in_data_b, int'(in_sel_b), WB, NB);
                e.sel  = 2'(in_sel_b);
                e.err  = (int'(in_sel_b) >= NB);
                q_b.push_back(e);
            end
        end
    end

    always @(negedge rst_n) begin
        q_a.delete();
        q_b.delete();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1; in_data_a = '0; in_sel_a = '0;
        flush_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b1; in_data_b = '0; in_sel_b = '0;
        repeat (2) @(posedge clk);
        #2;
        total++;
        if (out_valid_a !== 1'b0 || out_data_a !== '0 || out_sel_a !== '0 || sel_err_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_a: got valid=%b data=%h sel=%b err=%b, required all 0", out_valid_a, out_data_a, out_sel_a, sel_err_a);
        end
        total++;
        if (out_valid_b !== 1'b0 || out_data_b !== '0 || out_sel_b !== '0 || sel_err_b !== 1'b0) begin
            bad++;
            $display("FAIL reset_b: got valid=%b data=%h sel=%b err=%b, required all 0", out_valid_b, out_data_b, out_sel_b, sel_err_b);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        total++;
        if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got a=%b b=%b, required 1 1", in_ready_a, in_ready_b);
        end
    endtask

    task automatic test_basic();
        logic [4:0] exp_d;
        in_data_a   = {5'h00, 5'h1F};
        out_ready_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_a = 1'b1;
            in_sel_a   = 1'(i % 2);
            exp_d      = (i % 2 == 0) ? 5'h1F : 5'h00;
            tick();
            total++;
            if (out_valid_a !== 1'b1 || out_data_a !== exp_d) begin
                bad++;
                $display("FAIL basic_latency[%0d]: got valid=%b data=%h, required valid=1 data=%h", i, out_valid_a, out_data_a, exp_d);
            end
        end
        in_valid_a = 1'b0;
        tick();
        total++;
        if (out_valid_a !== 1'b0) begin
            bad++;
            $display("FAIL basic_drain: got valid=%b, required 0", out_valid_a);
        end
    endtask

    task automatic test_out_of_range();
        in_data_b   = {8'hC3, 8'hB2, 8'hA1};
        out_ready_b = 1'b1;
        in_valid_b  = 1'b1;
        in_sel_b    = 2'd2;
        tick();
        total++;
        if (out_valid_b !== 1'b1 || out_data_b !== 8'hC3 || sel_err_b !== 1'b0 || out_sel_b !== 2'd2) begin
            bad++;
            $display("FAIL oor_sel2: got valid=%b data=%h err=%b sel=%0d, required 1 c3 0 2", out_valid_b, out_data_b, sel_err_b, out_sel_b);
        end
        in_sel_b = 2'd3;
        tick();
        total++;
        if (out_valid_b !== 1'b1 || out_data_b !== 8'h00 || sel_err_b !== 1'b1 || out_sel_b !== 2'd3) begin
            bad++;
            $display("FAIL oor_sel3: got valid=%b data=%h err=%b sel=%0d, required 1 00 1 3", out_valid_b, out_data_b, sel_err_b, out_sel_b);
        end
        in_sel_b = 2'd0;
        tick();
        total++;
        if (out_data_b !== 8'hA1 || sel_err_b !== 1'b0) begin
            bad++;
            $display("FAIL oor_recover: got data=%h err=%b, required a1 0", out_data_b, sel_err_b);
        end
        in_valid_b = 1'b0;
        tick();
        total++;
        if (out_valid_b !== 1'b0 || sel_err_b !== 1'b0) begin
            bad++;
            $display("FAIL oor_idle: got valid=%b err=%b, required 0 0", out_valid_b, sel_err_b);
        end
    endtask

    task automatic test_backpressure();
        int         idx = 0;
        int         c = 0;
        int         start = out_cnt_b;
        logic       acc, stalled, exp_rdy;
        logic [7:0] held;
        in_sel_b = 2'd0;
        while ((idx < 4 || out_cnt_b - start < 4) && c < 40) begin
            c++;
            out_ready_b = !(c >= 2 && c <= 4);
            in_valid_b  = (idx < 4);
            in_data_b   = {16'h0, 8'(idx + 1)};
            #1;
`ifdef MUX_NX1_PIPE_SKID_EN
            exp_rdy = (q_b.size() < 2);
`else
            exp_rdy = (q_b.size() == 0) || out_ready_b;
`endif
            total++;
            if (in_ready_b !== exp_rdy) begin
                bad++;
                $display("FAIL bp_in_ready[c=%0d]: got %b, required %b", c, in_ready_b, exp_rdy);
            end
            acc     = in_valid_b && in_ready_b;
            stalled = out_valid_b && !out_ready_b;
            held    = out_data_b;
            tick();
            if (acc) idx++;
            if (stalled) begin
                total++;
                if (out_valid_b !== 1'b1 || out_data_b !== held) begin
                    bad++;
                    $display("FAIL bp_stall_hold[c=%0d]: got valid=%b data=%h, required 1 %h", c, out_valid_b, out_data_b, held);
                end
            end
        end
        in_valid_b  = 1'b0;
        out_ready_b = 1'b1;
        total++;
        if (out_cnt_b - start != 4 || idx != 4) begin
            bad++;
            $display("FAIL bp_count: got out=%0d accepted=%0d, required 4 4", out_cnt_b - start, idx);
        end
    endtask

    task automatic test_throughput();
        int         start = out_cnt_b;
        logic [7:0] exp_d;
        out_ready_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid_b = 1'b1;
            in_sel_b   = 2'(i % 3);
            in_data_b  = {8'(i * 3 + 2), 8'(i * 3 + 1), 8'(i * 3)};
            exp_d      = 8'(i * 3 + (i % 3));
            #1;
            total++;
            if (in_ready_b !== 1'b1) begin
                bad++;
                $display("FAIL tp_in_ready[%0d]: got %b, required 1", i, in_ready_b);
            end
            tick();
            total++;
            if (out_valid_b !== 1'b1 || out_data_b !== exp_d) begin
                bad++;
                $display("FAIL tp_out[%0d]: got valid=%b data=%h, required 1 %h", i, out_valid_b, out_data_b, exp_d);
            end
        end
        in_valid_b = 1'b0;
        tick();
        tick();
        total++;
        if (out_cnt_b - start != 16) begin
            bad++;
            $display("FAIL tp_count: got %0d, required 16", out_cnt_b - start);
        end
    endtask

    task automatic test_flush();
        int start;
        out_ready_b = 1'b1;
        in_valid_b  = 1'b1;
        in_sel_b    = 2'd0;
        in_data_b   = {16'h0, 8'h55};
        tick();
        out_ready_b = 1'b0;
        in_data_b   = {16'h0, 8'h66};
        tick();
`ifdef MUX_NX1_PIPE_SKID_EN
        total++;
        if (in_ready_b !== 1'b0) begin
            bad++;
            $display("FAIL flush_skid_full: got in_ready=%b, required 0", in_ready_b);
        end
`endif
        flush_b   = 1'b1;
        in_data_b = {16'h0, 8'h77};
        tick();
        flush_b    = 1'b0;
        in_valid_b = 1'b0;
        total++;
        if (out_valid_b !== 1'b0 || in_ready_b !== 1'b1) begin
            bad++;
            $display("FAIL flush_clear: got valid=%b in_ready=%b, required 0 1", out_valid_b, in_ready_b);
        end
        start       = out_cnt_b;
        out_ready_b = 1'b1;
        repeat (3) tick();
        total++;
        if (out_cnt_b != start) begin
            bad++;
            $display("FAIL flush_stale: got %0d words after flush, required 0", out_cnt_b - start);
        end
        flush_b    = 1'b1;
        in_valid_b = 1'b1;
        in_data_b  = {16'h0, 8'h99};
        tick();
        flush_b    = 1'b0;
        in_valid_b = 1'b0;
        total++;
        if (out_valid_b !== 1'b0) begin
            bad++;
            $display("FAIL flush_no_accept: got valid=%b data=%h, required valid=0", out_valid_b, out_data_b);
        end
        in_valid_b = 1'b1;
        in_data_b  = {16'h0, 8'h88};
        tick();
        in_valid_b = 1'b0;
        total++;
        if (out_valid_b !== 1'b1 || out_data_b !== 8'h88) begin
            bad++;
            $display("FAIL flush_next: got valid=%b data=%h, required 1 88", out_valid_b, out_data_b);
        end
        tick();
    endtask

    task automatic test_reset_midstall();
        out_ready_b = 1'b0;
        in_valid_b  = 1'b1;
        in_sel_b    = 2'd1;
        in_data_b   = {8'h00, 8'h3C, 8'h00};
        tick();
        in_valid_b = 1'b0;
        tick();
        total++;
        if (out_valid_b !== 1'b1 || out_data_b !== 8'h3C) begin
            bad++;
            $display("FAIL rst_pre_stall: got valid=%b data=%h, required 1 3c", out_valid_b, out_data_b);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid_b !== 1'b0 || out_data_b !== 8'h00 || sel_err_b !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: got valid=%b data=%h err=%b, required 0 00 0", out_valid_b, out_data_b, sel_err_b);
        end
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        out_ready_b = 1'b1;
        total++;
        if (in_ready_b !== 1'b1) begin
            bad++;
            $display("FAIL rst_release_ready: got %b, required 1", in_ready_b);
        end
        in_valid_b = 1'b1;
        in_sel_b   = 2'd2;
        in_data_b  = {8'h5A, 8'h00, 8'h00};
        tick();
        in_valid_b = 1'b0;
        total++;
        if (out_valid_b !== 1'b1 || out_data_b !== 8'h5A) begin
            bad++;
            $display("FAIL rst_first_word: got valid=%b data=%h, required 1 5a", out_valid_b, out_data_b);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_out_of_range();
        test_backpressure();
        test_throughput();
        test_flush();
        test_reset_midstall();
        tick();
        total++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got a=%0d b=%0d pending, required 0 0", q_a.size(), q_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
